// File: rtl/aes_pkg.sv
// aes_pkg: shared AES sequencer constants, FSM states and byte offset helper
package aes_pkg;
  localparam int AES_NR_128 = 10;
  localparam int STATE_W = 128;
  typedef enum logic [1:0] {IDLE, INIT, ROUND, DONE} fsm_e;
  function automatic int byte_off(input int c, input int r);
    return 32 * c + 8 * r;
  endfunction
endpackage

// File: rtl/aes_round_counter.sv
// aes_round_counter: round counter with terminal count on NR and mode-dependent key index
module aes_round_counter #(
  parameter int NR = aes_pkg::AES_NR_128,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          load,
  input  logic          inc,
  input  logic          mode,
  output logic [RW-1:0] round,
  output logic [RW-1:0] key_idx,
  output logic          last
);
  localparam logic [RW-1:0] NR_W = RW'(NR);
  logic [RW-1:0] round_q, round_d;
  always_comb round_d = clr ? '0 : load ? RW'(1) : inc ? round_q + RW'(1) : round_q;
  always_ff @(posedge clk) begin
    if (rst) round_q <= '0;
    else round_q <= round_d;
  end
  assign round = round_q;
  assign last = round_q == NR_W;
  assign key_idx = mode ? NR_W - round_q : round_q;
endmodule

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: iterative AES-128 round controller driving an external round datapath
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int NR = AES_NR_128,
  parameter int RW = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_mode,
  input  logic [STATE_W-1:0] in_data,
  input  logic               abort,
  output logic [STATE_W-1:0] dp_state,
  input  logic [STATE_W-1:0] dp_result,
  output logic [RW-1:0]      dp_round,
  output logic [RW-1:0]      dp_key_idx,
  output logic               dp_first,
  output logic               dp_last,
  output logic               dp_inverse,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_data,
  output logic               busy
);
  fsm_e fsm_q, fsm_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic mode_q, mode_d;
  logic accept, active, last;
  logic [RW-1:0] round, key_idx;
  assign in_ready = fsm_q == IDLE || (fsm_q == DONE && out_ready);
  assign accept = in_valid && in_ready && !abort;
  assign active = fsm_q == INIT || fsm_q == ROUND;
  aes_round_counter #(.NR(NR), .RW(RW)) u_cnt (
    .clk,
    .rst,
    .clr(abort || accept),
    .load(fsm_q == INIT),
    .inc(fsm_q == ROUND && !last),
    .mode(mode_q),
    .round,
    .key_idx,
    .last
  );
  always_comb begin
    fsm_d = fsm_q;
    state_d = state_q;
    mode_d = mode_q;
    if (active) state_d = dp_result;
    if (fsm_q == INIT) fsm_d = ROUND;
    if (fsm_q == ROUND && last) fsm_d = DONE;
    if (fsm_q == DONE && out_ready) fsm_d = IDLE;
    if (accept) begin
      state_d = in_data;
      mode_d = in_mode;
      fsm_d = INIT;
    end
    if (abort) begin
      fsm_d = IDLE;
      state_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= IDLE;
      state_q <= '0;
      mode_q <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      state_q <= state_d;
      mode_q <= mode_d;
    end
  end
  assign busy = active;
  assign dp_state = state_q;
  assign out_data = state_q;
  assign out_valid = fsm_q == DONE;
  assign dp_first = fsm_q == INIT;
  assign dp_last = fsm_q == ROUND && last;
  assign dp_inverse = mode_q;
  assign dp_round = fsm_q == ROUND ? round : '0;
  assign dp_key_idx = active ? key_idx : '0;
endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer: randomized self-checking bench with a behavioural AES round datapath
module tb_aes_round_sequencer;
  localparam int NR = 10;
  localparam int RW = 4;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_mode, abort, out_valid, out_ready, busy;
  logic dp_first, dp_last, dp_inverse;
  logic [127:0] in_data, dp_state, dp_result, out_data;
  logic [RW-1:0] dp_round, dp_key_idx;
  logic [2*RW+5:0] ctrl;
  logic [7:0] sb[256];
  logic [7:0] isb[256];
  logic [127:0] rk[11];
  int nvec = 0;
  int nerr = 0;
  always #5 clk = ~clk;
  assign ctrl = {busy, in_ready, out_valid, dp_first, dp_last, dp_inverse, dp_round, dp_key_idx};
  aes_round_sequencer #(.NR(NR), .RW(RW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_data(in_data), .abort(abort), .dp_state(dp_state), .dp_result(dp_result),
    .dp_round(dp_round), .dp_key_idx(dp_key_idx), .dp_first(dp_first), .dp_last(dp_last),
    .dp_inverse(dp_inverse), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction
  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction
  function automatic logic [127:0] bs(input logic [127:0] x);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i+:8] = x[8*(15-i)+:8];
    return o;
  endfunction
  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i+:8] = inv ? isb[s[8*i+:8]] : sb[s[8*i+:8]];
    return o;
  endfunction
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(4*c+r)+:8] = s[8*(4*((inv ? c - r + 4 : c + r) % 4) + r)+:8];
    return o;
  endfunction
  function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [7:0] cf[4];
    logic [7:0] acc;
    cf = inv ? '{8'h0e, 8'h0b, 8'h0d, 8'h09} : '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc ^= gm(s[8*(4*c+j)+:8], cf[(j - r + 4) % 4]);
        o[8*(4*c+r)+:8] = acc;
      end
    return o;
  endfunction
  function automatic logic [127:0] dp_fn(input logic [127:0] s, input logic first, input logic last,
                                         input logic inv, input logic [RW-1:0] k);
    logic [127:0] key, t;
    key = (int'(k) <= NR) ? rk[k] : '0;
    if (first) return s ^ key;
    if (!inv) begin
      t = shift_rows(sub_bytes(s, 1'b0), 1'b0);
      return (last ? t : mix_columns(t, 1'b0)) ^ key;
    end
    t = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ key;
    return last ? t : mix_columns(t, 1'b1);
  endfunction
  function automatic logic [127:0] enc(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rk[0];
    for (int r = 1; r <= NR; r++) s = dp_fn(s, 1'b0, r == NR, 1'b0, RW'(r));
    return s;
  endfunction
  function automatic logic [2*RW+5:0] exp_busy(input int k, input logic m);
    return {1'b1, 1'b0, 1'b0, k == 1, k == NR + 1, m, RW'(k - 1), RW'(m ? NR - k + 1 : k - 1)};
  endfunction
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic build_model(input logic [127:0] key);
    logic [7:0] inv, s, rc;
    logic [31:0] w[44];
    logic [31:0] t;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        repeat (254) inv = gm(inv, 8'(x));
      end
      s = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
      sb[x] = s;
      isb[s] = 8'(x);
    end
    rc = 8'h01;
    for (int i = 0; i < 44; i++) begin
      if (i < 4) w[i] = key[32*i+:32];
      else begin
        t = w[i-1];
        if (i % 4 == 0) begin
          t = {t[7:0], t[31:8]};
          t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {24'h0, rc};
          rc = xt(rc);
        end
        w[i] = w[i-4] ^ t;
      end
    end
    for (int n = 0; n <= NR; n++) rk[n] = {w[4*n+3], w[4*n+2], w[4*n+1], w[4*n]};
  endtask
  initial begin
    dp_result = '0;
    forever begin
      @(posedge clk);
      #2;
      dp_result = dp_fn(dp_state, dp_first, dp_last, dp_inverse, dp_key_idx);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    if (ctrl !== {2'b01, {(2*RW+4){1'b0}}}) begin
      nerr++;
      $display("FAIL reset_ctrl got=%h exp=%h", ctrl, {2'b01, {(2*RW+4){1'b0}}});
    end
    nvec++;
    if (out_data !== '0) begin
      nerr++;
      $display("FAIL reset_data got=%h exp=0", out_data);
    end
    rst = 1'b0;
    tick();
  endtask
  task automatic test_block(input string nm, input logic [127:0] din, input logic m, input logic [127:0] ex);
    nvec++;
    if (in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL %s idle_in_ready got=%b exp=1", nm, in_ready);
    end
    in_valid = 1'b1;
    in_mode = m;
    in_data = din;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= NR + 1; k++) begin
      nvec++;
      if (ctrl !== exp_busy(k, m)) begin
        nerr++;
        $display("FAIL %s ctrl cyc=%0d got=%h exp=%h", nm, k, ctrl, exp_busy(k, m));
      end
      tick();
    end
    nvec++;
    if (ctrl !== {3'b001, 2'b00, m, {(2*RW){1'b0}}}) begin
      nerr++;
      $display("FAIL %s done_ctrl got=%h exp=%h", nm, ctrl, {3'b001, 2'b00, m, {(2*RW){1'b0}}});
    end
    nvec++;
    if (out_data !== ex) begin
      nerr++;
      $display("FAIL %s out_data got=%h exp=%h", nm, out_data, ex);
    end
    out_ready = 1'b1;
    #1;
    nvec++;
    if (in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL %s done_in_ready got=%b exp=1", nm, in_ready);
    end
    tick();
    out_ready = 1'b0;
    nvec++;
    if ({busy, out_valid, in_ready} !== 3'b001) begin
      nerr++;
      $display("FAIL %s back_idle got=%b exp=001", nm, {busy, out_valid, in_ready});
    end
  endtask
  task automatic test_backpressure();
    logic [127:0] p1, p2;
    p1 = rnd128();
    p2 = rnd128();
    in_valid = 1'b1;
    in_mode = 1'b0;
    in_data = p1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (NR + 1) tick();
    in_valid = 1'b1;
    in_data = p2;
    for (int i = 0; i < 5; i++) begin
      nvec++;
      if ({out_valid, in_ready} !== 2'b10 || out_data !== enc(p1)) begin
        nerr++;
        $display("FAIL bp_hold i=%0d valid_ready=%b data=%h exp=10 %h", i, {out_valid, in_ready}, out_data, enc(p1));
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    nvec++;
    if ({out_valid, in_ready} !== 2'b11) begin
      nerr++;
      $display("FAIL bp_release got=%b exp=11", {out_valid, in_ready});
    end
    tick();
    out_ready = 1'b0;
    in_valid = 1'b0;
    nvec++;
    if (ctrl !== exp_busy(1, 1'b0)) begin
      nerr++;
      $display("FAIL bp_next_init got=%h exp=%h", ctrl, exp_busy(1, 1'b0));
    end
    repeat (NR + 1) tick();
    nvec++;
    if (out_valid !== 1'b1 || out_data !== enc(p2)) begin
      nerr++;
      $display("FAIL bp_second got=%b %h exp=1 %h", out_valid, out_data, enc(p2));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask
  task automatic test_back_to_back();
    logic [127:0] a, b;
    a = rnd128();
    b = rnd128();
    in_valid = 1'b1;
    in_mode = 1'b0;
    in_data = a;
    out_ready = 1'b1;
    tick();
    in_data = b;
    for (int c = 1; c <= 2 * NR + 5; c++) begin
      nvec++;
      if (out_valid !== (c == NR + 2 || c == 2 * NR + 4)) begin
        nerr++;
        $display("FAIL b2b_valid cyc=%0d got=%b exp=%b", c, out_valid, c == NR + 2 || c == 2 * NR + 4);
      end
      if (c == NR + 2) begin
        nvec++;
        if (out_data !== enc(a)) begin
          nerr++;
          $display("FAIL b2b_first got=%h exp=%h", out_data, enc(a));
        end
      end
      if (c == NR + 3) begin
        nvec++;
        if (dp_first !== 1'b1) begin
          nerr++;
          $display("FAIL b2b_init got=%b exp=1", dp_first);
        end
        in_valid = 1'b0;
      end
      if (c == 2 * NR + 4) begin
        nvec++;
        if (out_data !== enc(b)) begin
          nerr++;
          $display("FAIL b2b_second got=%h exp=%h", out_data, enc(b));
        end
      end
      tick();
    end
    out_ready = 1'b0;
  endtask
  task automatic test_abort();
    logic seen;
    logic [127:0] p;
    in_valid = 1'b1;
    in_mode = 1'b0;
    in_data = rnd128();
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    nvec++;
    if (dp_round !== RW'(5)) begin
      nerr++;
      $display("FAIL abort_round got=%0d exp=5", dp_round);
    end
    abort = 1'b1;
    in_valid = 1'b1;
    in_data = rnd128();
    tick();
    abort = 1'b0;
    in_valid = 1'b0;
    nvec++;
    if ({busy, in_ready, out_valid} !== 3'b010 || dp_state !== '0) begin
      nerr++;
      $display("FAIL abort_idle got=%b %h exp=010 0", {busy, in_ready, out_valid}, dp_state);
    end
    seen = 1'b0;
    repeat (NR + 3) begin
      if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      tick();
    end
    nvec++;
    if (seen !== 1'b0) begin
      nerr++;
      $display("FAIL abort_quiet got=%b exp=0", seen);
    end
    p = rnd128();
    test_block("after_abort", p, 1'b0, enc(p));
  endtask
  task automatic test_reset_mid();
    in_valid = 1'b1;
    in_mode = 1'b1;
    in_data = rnd128();
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    nvec++;
    if (dp_round !== RW'(3)) begin
      nerr++;
      $display("FAIL rstmid_round got=%0d exp=3", dp_round);
    end
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = rnd128();
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    nvec++;
    if (ctrl !== {2'b01, {(2*RW+4){1'b0}}} || out_data !== '0) begin
      nerr++;
      $display("FAIL rstmid_state got=%h %h exp=%h 0", ctrl, out_data, {2'b01, {(2*RW+4){1'b0}}});
    end
    tick();
    nvec++;
    if ({busy, in_ready} !== 2'b01) begin
      nerr++;
      $display("FAIL rstmid_noaccept got=%b exp=01", {busy, in_ready});
    end
  endtask
  initial begin
    logic [127:0] p, c;
    logic m;
    rst = 1'b1;
    in_valid = 1'b0;
    in_mode = 1'b0;
    in_data = '0;
    abort = 1'b0;
    out_ready = 1'b0;
    build_model(bs(128'h000102030405060708090a0b0c0d0e0f));
    test_reset();
    test_block("enc_kat", bs(128'h00112233445566778899aabbccddeeff), 1'b0, bs(128'h69c4e0d86a7b0430d8cdb78070b4c55a));
    test_block("dec_kat", bs(128'h69c4e0d86a7b0430d8cdb78070b4c55a), 1'b1, bs(128'h00112233445566778899aabbccddeeff));
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    for (int i = 0; i < 6; i++) begin
      p = rnd128();
      m = 1'($urandom_range(0, 1));
      c = enc(p);
      test_block("random", m ? c : p, m, m ? p : c);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
